// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register with a 2-entry skid buffer and occupancy report.
// Optional stall/bubble performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // State encoding doubles as the occupancy count, so occ exposes the FSM directly.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              acc;
   logic              pop;

   // Handshake: a beat moves on a port in any cycle where valid and ready are both high
   // at the rising edge; in_ready and out_valid depend only on registered state.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occ       = state_q;
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else if (flush) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_q <= ONE;
                  main_q  <= in_data;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  main_q <= in_data;
               end else if (acc) begin
                  state_q <= FULL;
                  skid_q  <= in_data;
               end else if (pop) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_q <= ONE;
                  main_q  <= skid_q;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] stall_d;
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] bubble_d;

   // Saturating counters; flush deliberately leaves them untouched.
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (!out_valid && out_ready && (bubble_q != '1)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed test-plan scenarios plus random traffic,
// all checked against a queue-based model of the stage.
module tb_pipe_stage_elastic;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam logic [DW-1:0] RV = 8'h5A;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [1:0] occ;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_elastic #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // ---------------- behavioural model ----------------
  // Held beats live in a FIFO of depth 2; idle_data is what the output register shows when empty.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_idle = RV;
  int m_stall = 0;
  int m_bubble = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exp_q.delete();
      m_idle = RV;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      bit mv, macc, mpop;
      mv = (exp_q.size() > 0);
      if (mv && !out_ready && m_stall < CNT_MAX) m_stall++;
      if (!mv && out_ready && m_bubble < CNT_MAX) m_bubble++;
      if (flush) begin
        exp_q.delete();
        m_idle = RV;
      end else begin
        macc = in_valid && (exp_q.size() < 2);
        mpop = mv && out_ready;
        if (mpop) m_idle = exp_q.pop_front();
        if (macc) exp_q.push_back(in_data);
      end
    end
  end

  function automatic int exp_stall();
`ifdef PIPE_STAGE_PERF_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_bubble();
`ifdef PIPE_STAGE_PERF_EN
    return m_bubble;
`else
    return 0;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;
  always @(negedge CLK) begin
    if (cmp_en && nRST) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("cyc_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("cyc_occ", 32'(occ), 32'(exp_q.size()));
      chk("cyc_out_data", 32'(out_data), 32'((exp_q.size() > 0) ? exp_q[0] : m_idle));
      chk("cyc_stall_cnt", 32'(stall_cnt), 32'(exp_stall()));
      chk("cyc_bubble_cnt", 32'(bubble_cnt), 32'(exp_bubble()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic rdy_before;
    int sat_exp;
`ifdef PIPE_STAGE_PERF_EN
    sat_exp = CNT_MAX;
`else
    sat_exp = 0;
`endif
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(RV));
    nRST = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Streaming with out_ready held high.
    drive(1, 8'h11, 1, 0); tick();
    chk("stream_d0", 32'(out_data), 32'h11);
    chk("stream_occ0", 32'(occ), 32'd1);
    drive(1, 8'h22, 1, 0); tick();
    chk("stream_d1", 32'(out_data), 32'h22);
    chk("stream_rdy1", 32'(in_ready), 32'd1);
    drive(1, 8'h33, 1, 0); tick();
    chk("stream_d2", 32'(out_data), 32'h33);
    chk("stream_occ2", 32'(occ), 32'd1);
    drive(0, 8'h00, 1, 0); tick();
    chk("stream_drain", 32'(occ), 32'd0);

    // Backpressure fill, refused third beat, then ordered drain.
    drive(1, 8'hA0, 0, 0); tick();
    drive(1, 8'hB0, 0, 0); tick();
    chk("bp_occ_full", 32'(occ), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drive(1, 8'hC0, 0, 0); tick();
    chk("bp_refused_occ", 32'(occ), 32'd2);
    chk("bp_head", 32'(out_data), 32'hA0);
    drive(1, 8'hC0, 1, 0); tick();
    chk("bp_drain_b0", 32'(out_data), 32'hB0);
    tick();
    chk("bp_drain_c0", 32'(out_data), 32'hC0);
    drive(0, 8'h00, 1, 0); tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Flush while FULL with a simultaneous accept and pop.
    drive(1, 8'hE1, 0, 0); tick();
    drive(1, 8'hE2, 0, 0); tick();
    chk("fl_pre_occ", 32'(occ), 32'd2);
    drive(1, 8'hDD, 1, 1); tick();
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data", 32'(out_data), 32'(RV));
    drive(0, 8'h00, 1, 0);
    repeat (3) begin
      tick();
      chk("fl_no_dd", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between edges while FULL.
    drive(1, 8'hF1, 0, 0); tick();
    drive(1, 8'hF2, 0, 0); tick();
    drive(0, 8'h00, 0, 0);
    chk("ar_pre_occ", 32'(occ), 32'd2);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_occ", 32'(occ), 32'd0);
    chk("ar_out_data", 32'(out_data), 32'(RV));
    tick();
    nRST = 1'b1;
    tick();

    // Stall counter saturation, survives flush, cleared by reset.
    drive(1, 8'h77, 0, 0); tick();
    drive(0, 8'h00, 0, 0);
    repeat (20) tick();
    chk("perf_stall_sat", 32'(stall_cnt), 32'(sat_exp));
    drive(0, 8'h00, 0, 1); tick();
    drive(0, 8'h00, 0, 0); tick();
    chk("perf_stall_after_flush", 32'(stall_cnt), 32'(sat_exp));
    cmp_en = 1'b0;
    nRST = 1'b0;
    #1;
    chk("perf_stall_rst", 32'(stall_cnt), 32'd0);
    chk("perf_bubble_rst", 32'(bubble_cnt), 32'd0);
    tick();
    nRST = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Random traffic; an unaccepted beat is held until it is taken.
    drive(0, 8'h00, 0, 0);
    for (int i = 0; i < 800; i++) begin
      if (!in_valid || rdy_before) begin
        in_valid = ($urandom_range(0, 99) < 65);
        in_data = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 49) == 0);
      rdy_before = in_ready;
      tick();
      if (flush) rdy_before = 1'b1;
    end
    drive(0, 8'h00, 1, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
